// File: rtl/data_mem_controller.sv
// Data memory owner: MEM-stage passthrough plus a post-halt dump sequencer.
// Optional macro DUMP_RANGE_EN adds dump_first/dump_last range ports.
module data_mem_controller #(
  parameter int LEN_DATA  = 32,
  parameter int ADDR_BITS = 8,
  parameter int RAM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_rd,
  input  logic                 pipe_wr,
  input  logic [ADDR_BITS-1:0] pipe_addr,
  input  logic [LEN_DATA-1:0]  pipe_wdata,
  output logic [LEN_DATA-1:0]  pipe_rdata,
  input  logic                 halt_flag,
  input  logic                 dump_start,
  output logic [LEN_DATA-1:0]  dump_data,
  output logic [ADDR_BITS-1:0] dump_addr,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic                 dump_done,
  output logic                 busy,
  output logic                 conflict,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [LEN_DATA-1:0]  mem_wdata,
`ifdef DUMP_RANGE_EN
  input  logic [ADDR_BITS-1:0] dump_first,
  input  logic [ADDR_BITS-1:0] dump_last,
`endif
  input  logic [LEN_DATA-1:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    DUMP_RD,
    DUMP_WAIT,
    DONE
  } state_t;

  localparam int CW = ADDR_BITS + 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] first_w, last_w;
  logic          accept, empty, xfer;

  assign accept    = (state == IDLE) & dump_start & halt_flag;
  assign xfer      = dump_valid & dump_ready;
  assign busy      = (state != IDLE);
  assign dump_done = (state == DONE);

`ifdef DUMP_RANGE_EN
  logic [ADDR_BITS-1:0] last_q;

  assign first_w = {1'b0, dump_first};
  assign empty   = (dump_first > dump_last);
  assign last_w  = {1'b0, last_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else if (accept) begin
      last_q <= dump_last;
    end
  end
`else
  assign first_w = '0;
  assign empty   = 1'b0;
  assign last_w  = CW'(RAM_DEPTH - 1);
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = cnt[ADDR_BITS-1:0];
    mem_wdata  = '0;
    pipe_rdata = '0;
    unique case (state)
      IDLE: begin
        mem_rd     = pipe_rd;
        mem_wr     = pipe_wr;
        mem_addr   = pipe_addr;
        mem_wdata  = pipe_wdata;
        pipe_rdata = mem_rdata;
        if (accept) begin
          cnt_nx   = first_w;
          state_nx = empty ? DONE : DUMP_RD;
        end
      end
      DUMP_RD: begin
        mem_rd   = 1'b1;
        state_nx = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (xfer) begin
          if (cnt == last_w) begin
            state_nx = DONE;
          end else begin
            cnt_nx   = cnt + 1'b1;
            state_nx = DUMP_RD;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Dump word register holds until the handshake completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_data  <= '0;
      dump_addr  <= '0;
      dump_valid <= 1'b0;
    end else if (state == DUMP_RD) begin
      dump_data  <= mem_rdata;
      dump_addr  <= cnt[ADDR_BITS-1:0];
      dump_valid <= 1'b1;
    end else if (state == DUMP_WAIT && xfer) begin
      dump_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict <= 1'b0;
    end else if (busy && (pipe_rd || pipe_wr)) begin
      conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller with a falling-edge memory model.
// Build with +define+DUMP_RANGE_EN to exercise the range ports.
module tb_data_mem_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_rd, pipe_wr;
  logic [7:0]  pipe_addr;
  logic [31:0] pipe_wdata, pipe_rdata;
  logic        halt_flag, dump_start;
  logic [31:0] dump_data;
  logic [7:0]  dump_addr;
  logic        dump_valid, dump_ready, dump_done;
  logic        busy, conflict;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0]  dump_first, dump_last;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  data_mem_controller dut (
    .clk(clk), .reset(reset),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata),
    .halt_flag(halt_flag), .dump_start(dump_start),
    .dump_data(dump_data), .dump_addr(dump_addr),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_done(dump_done), .busy(busy), .conflict(conflict),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DUMP_RANGE_EN
    .dump_first(dump_first), .dump_last(dump_last),
`endif
    .mem_rdata(mem_rdata)
  );

  // Single-port RAM clocked on the falling edge
  always @(negedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #3;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode 0: ready high, 1: random ready/start + halt drop, 2: stall word 7
  task automatic dump_run(input int mode, input int first, input int last,
                          input int exp_lat);
    int cyc, words, dones, stall, exp_a, exp_n, lo, hi;
    bit saw_valid;
    cyc = 0; words = 0; dones = 0; stall = 0; saw_valid = 0;
    dump_first = first[7:0];
    dump_last  = last[7:0];
`ifdef DUMP_RANGE_EN
    lo = int'(dump_first);
    hi = int'(dump_last);
`else
    lo = 0;
    hi = 255;
`endif
    exp_n = (lo > hi) ? 0 : hi - lo + 1;
    exp_a = lo;
    halt_flag  = 1'b1;
    dump_start = 1'b1;
    dump_ready = 1'b0;
    tick();
    dump_start = 1'b0;
    if (mode == 1) halt_flag = 1'b0;
    while (dones == 0 && cyc < 1500) begin
      if (mode == 1) begin
        dump_ready = 1'($urandom_range(0, 1));
        dump_start = ($urandom_range(0, 3) == 0);
      end else if (mode == 2 && dump_valid && dump_addr == 8'd7 && stall < 5) begin
        dump_ready = 1'b0;
        stall++;
      end else begin
        dump_ready = 1'b1;
      end
      peek();
      cyc++;
      if (dump_valid) saw_valid = 1'b1;
      if (mode == 2 && !dump_ready) begin
        chk("stall_valid", 32'(dump_valid), 32'd1);
        chk("stall_data", dump_data, 32'd21);
      end
      if (dump_valid && dump_ready) begin
        chk("dump_addr", 32'(dump_addr), 32'(exp_a));
        chk("dump_data", dump_data, ref_mem[exp_a[7:0]]);
        words++;
        if (exp_a < 255) exp_a++;
      end
      if (dump_done) dones++;
      tick();
    end
    dump_start = 1'b0;
    dump_ready = 1'b0;
    chk("dump_words", 32'(words), 32'(exp_n));
    chk("done_seen", 32'(dones), 32'd1);
    if (mode == 2) chk("stall_cycles", 32'(stall), 32'd5);
    if (exp_lat > 0) chk("dump_latency", 32'(cyc), 32'(exp_lat));
    if (exp_n == 0) chk("no_valid", 32'(saw_valid), 32'd0);
    peek();
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_single", 32'(dump_done), 32'd0);
    tick();
  endtask

  initial begin
    int bad;
    tbl[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 8'h20, 32'h12345678, 32'h0};
    tbl[3] = '{1'b1, 8'h10, 32'hCAFEF00D, 32'h0};
    tbl[4] = '{1'b0, 8'h20, 32'h0,        32'h12345678};
    tbl[5] = '{1'b0, 8'h10, 32'h0,        32'hCAFEF00D};

    mem_rdata = '0;
    reset = 1'b0;
    pipe_rd = 0; pipe_wr = 0; pipe_addr = '0; pipe_wdata = '0;
    halt_flag = 0; dump_start = 0; dump_ready = 0;
    dump_first = '0; dump_last = 8'hFF;

    peek();
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_addr", 32'(dump_addr), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      pipe_wr = tbl[i].wr;
      pipe_rd = !tbl[i].wr;
      pipe_addr = tbl[i].addr;
      pipe_wdata = tbl[i].wdata;
      if (tbl[i].wr) ref_mem[tbl[i].addr] = tbl[i].wdata;
      peek();
      chk("pt_mem_wr", 32'(mem_wr), 32'(tbl[i].wr));
      chk("pt_mem_addr", 32'(mem_addr), 32'(tbl[i].addr));
      chk("pt_busy", 32'(busy), 32'd0);
      if (!tbl[i].wr) chk("pt_rdata", pipe_rdata, tbl[i].exp_rdata);
      tick();
    end
    pipe_rd = 0; pipe_wr = 0;

    // halt gating
    dump_start = 1'b1;
    halt_flag = 1'b0;
    tick();
    dump_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      peek();
      if (busy || dump_valid) bad++;
      tick();
    end
    chk("halt_gate", 32'(bad), 32'd0);

    // preload mem[i] = i*3 through the pipeline port
    for (int i = 0; i < 256; i++) begin
      pipe_wr = 1'b1;
      pipe_addr = 8'(i);
      pipe_wdata = 32'(i * 3);
      ref_mem[i] = 32'(i * 3);
      tick();
    end
    pipe_wr = 1'b0;

    dump_run(0, 0, 255, 513);
    dump_run(2, 0, 255, 0);

    // random IDLE traffic against the reference array
    for (int i = 0; i < 60; i++) begin
      pipe_addr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        pipe_wr = 1'b1;
        pipe_wdata = $urandom;
        ref_mem[pipe_addr] = pipe_wdata;
        tick();
        pipe_wr = 1'b0;
      end else begin
        pipe_rd = 1'b1;
        peek();
        chk("rand_rd", pipe_rdata, ref_mem[pipe_addr]);
        tick();
        pipe_rd = 1'b0;
      end
    end

    dump_run(1, 0, 255, 0);

`ifdef DUMP_RANGE_EN
    dump_run(0, 4, 6, 0);
    dump_run(0, 9, 2, 0);
`endif

    // conflict during DUMP_WAIT, then abort with reset
    halt_flag = 1'b1;
    dump_start = 1'b1;
    dump_ready = 1'b0;
    tick();
    dump_start = 1'b0;
    peek();
    chk("start_busy", 32'(busy), 32'd1);
    tick();
    pipe_rd = 1'b1;
    peek();
    chk("cf_valid", 32'(dump_valid), 32'd1);
    chk("cf_mem_rd", 32'(mem_rd), 32'd0);
    chk("cf_rdata", pipe_rdata, 32'd0);
    tick();
    pipe_rd = 1'b0;
    chk("conflict_set", 32'(conflict), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(dump_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_conflict", 32'(conflict), 32'd0);
    chk("abort_data", dump_data, 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) reset = 1'b1;
      peek();
      if (dump_done || busy) bad++;
      tick();
    end
    chk("abort_no_done", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
